// File: rtl/uart_frame_packer.sv
// -----------------------------------------------------------------------------
// uart_frame_packer
//
// Captures each averaged temperature sample with its warning flag and sends it
// to the UART transmitter as a 5-byte checksummed frame:
//   B0 = HEADER, B1 = sequence number, B2 = sample, B3 = {6'b0, ovr, warn},
//   B4 = two's-complement checksum (8-bit sum of B0..B4 is zero).
// One sample can wait in a pending register while a frame is being sent; if a
// second sample arrives before the pending one is taken, the older one is lost
// and the overrun condition is recorded.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   sample_valid  one-cycle pulse, new averaged sample available
//   sample_data   averaged temperature, valid with sample_valid
//   temp_warn     hysteresis warning level, sampled with sample_data
//   tx_busy       UART transmitter busy
//   tx_start      one-cycle pulse, UART loads tx_data
//   tx_data       byte to transmit, held until the next byte is loaded
//   frame_active  high from frame load until the last byte completes
//   overrun       sticky overrun indicator, cleared only by reset
// -----------------------------------------------------------------------------
module uart_frame_packer #(
   parameter logic [7:0]  HEADER       = 8'hA5,
   parameter int unsigned BUSY_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sample_valid,
   input  logic [7:0] sample_data,
   input  logic       temp_warn,
   input  logic       tx_busy,
   output logic       tx_start,
   output logic [7:0] tx_data,
   output logic       frame_active,
   output logic       overrun
);

   localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SEND,
      WAIT_HI,
      WAIT_LO,
      NEXT
   } state_t;

   state_t        state;
   state_t        state_nxt;

   // pending sample buffer
   logic [7:0]    pend_data;
   logic          pend_warn;
   logic          pend_full;
   logic          ovr_flag;

   // frame contents, frozen at LOAD for the whole transmission
   logic [7:0]    seq;
   logic [7:0]    f_seq;
   logic [7:0]    f_sample;
   logic [7:0]    f_flags;
   logic [7:0]    f_csum;

   logic [2:0]    idx;
   logic [TW-1:0] to_cnt;
   logic          timeout;
   logic [7:0]    flags_nxt;
   logic [7:0]    csum_nxt;
   logic [7:0]    following_byte;

   assign timeout   = (to_cnt == TW'(BUSY_TIMEOUT));
   assign flags_nxt = {6'b0, ovr_flag, pend_warn};
   assign csum_nxt  = 8'h00 - (HEADER + seq + pend_data + flags_nxt);

   // byte that follows B[idx]; B0 is loaded directly at LOAD
   always_comb begin
      following_byte = f_csum;
      case (idx)
         3'd0:    following_byte = f_seq;
         3'd1:    following_byte = f_sample;
         3'd2:    following_byte = f_flags;
         default: following_byte = f_csum;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // tx_start is decoded from SEND and tx_busy so the first byte leaves in the
   // cycle after LOAD rather than one cycle later.
   always_comb begin
      state_nxt = state;
      tx_start  = 1'b0;
      case (state)
         IDLE: begin
            if (pend_full) state_nxt = LOAD;
         end
         LOAD: begin
            state_nxt = SEND;
         end
         SEND: begin
            if (!tx_busy) begin
               tx_start  = 1'b1;
               state_nxt = WAIT_HI;
            end
         end
         WAIT_HI: begin
            if (tx_busy)      state_nxt = WAIT_LO;
            else if (timeout) state_nxt = NEXT;
         end
         WAIT_LO: begin
            if (!tx_busy) state_nxt = NEXT;
         end
         NEXT: begin
            state_nxt = (idx == 3'd4) ? IDLE : SEND;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_data    <= '0;
         pend_warn    <= 1'b0;
         pend_full    <= 1'b0;
         ovr_flag     <= 1'b0;
         overrun      <= 1'b0;
         seq          <= '0;
         f_seq        <= '0;
         f_sample     <= '0;
         f_flags      <= '0;
         f_csum       <= '0;
         idx          <= '0;
         to_cnt       <= '0;
         tx_data      <= '0;
         frame_active <= 1'b0;
      end else begin
         // A sample arriving during LOAD refills the slot being emptied, so it
         // does not count as an overrun.
         if (sample_valid) begin
            pend_data <= sample_data;
            pend_warn <= temp_warn;
            pend_full <= 1'b1;
            if (pend_full && (state != LOAD)) begin
               ovr_flag <= 1'b1;
               overrun  <= 1'b1;
            end
         end else if (state == LOAD) begin
            pend_full <= 1'b0;
         end

         if (state == LOAD) begin
            f_seq        <= seq;
            f_sample     <= pend_data;
            f_flags      <= flags_nxt;
            f_csum       <= csum_nxt;
            ovr_flag     <= 1'b0;
            tx_data      <= HEADER;
            frame_active <= 1'b1;
            idx          <= '0;
         end

         if (state == SEND) begin
            to_cnt <= '0;
         end else if ((state == WAIT_HI) && !tx_busy && !timeout) begin
            to_cnt <= to_cnt + TW'(1);
         end

         if (state == NEXT) begin
            if (idx == 3'd4) begin
               seq          <= seq + 8'd1;
               frame_active <= 1'b0;
            end else begin
               idx     <= idx + 3'd1;
               tx_data <= following_byte;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_packer.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_packer
//
// Directed bench for uart_frame_packer. Expected frames are built from the
// frame layout rules (header, sequence, sample, flags, checksum) and queued as
// samples are sent; a monitor compares every transmitted byte against that
// queue and checks byte spacing against the UART handshake timing.
// -----------------------------------------------------------------------------
module tb_uart_frame_packer;

   logic       clk;
   logic       rst_n;
   logic       sample_valid;
   logic [7:0] sample_data;
   logic       temp_warn;
   logic       tx_busy;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       frame_active;
   logic       overrun;

   uart_frame_packer #(
      .HEADER       (8'hA5),
      .BUSY_TIMEOUT (16)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .temp_warn    (temp_warn),
      .tx_busy      (tx_busy),
      .tx_start     (tx_start),
      .tx_data      (tx_data),
      .frame_active (frame_active),
      .overrun      (overrun)
   );

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned cyc      = 0;

   // model state
   logic [7:0]  exp_q[$];
   logic [7:0]  m_seq;
   bit          uart_mode;        // 0: busy for 10 cycles, 1: never busy
   int unsigned busy_cnt = 0;

   // monitor state
   int unsigned byte_idx    = 0;
   int unsigned frames_done = 0;
   int unsigned last_start  = 0;
   logic [7:0]  cur_frame[5];
   logic [7:0]  last_frame[5];

   assign tx_busy = (busy_cnt != 0);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      chk32(name, {24'b0, act}, {24'b0, exp});
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk32(name, {31'b0, act}, {31'b0, exp});
   endtask

   task automatic chk_frame(input string name, input logic [39:0] exp);
      logic [39:0] act;
      act = {last_frame[0], last_frame[1], last_frame[2], last_frame[3], last_frame[4]};
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %010h, expected %010h", name, act, exp);
      end
   endtask

   // Build the frame the rules require and queue its bytes.
   task automatic expect_frame(input logic [7:0] s, input logic w, input logic o);
      logic [7:0] b[5];
      int         sum;
      b[0] = 8'hA5;
      b[1] = m_seq;
      b[2] = s;
      b[3] = {6'b0, o, w};
      sum  = int'(b[0]) + int'(b[1]) + int'(b[2]) + int'(b[3]);
      b[4] = 8'((256 - (sum % 256)) % 256);
      for (int i = 0; i < 5; i++) exp_q.push_back(b[i]);
      m_seq = m_seq + 8'd1;
   endtask

   // UART responder
   initial begin
      forever begin
         @(posedge clk);
         if (!rst_n)                      busy_cnt <= 0;
         else if (!uart_mode && tx_start) busy_cnt <= 10;
         else if (busy_cnt != 0)          busy_cnt <= busy_cnt - 1;
      end
   end

   // Byte monitor / compare process
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            byte_idx = 0;
         end else if (tx_start) begin
            chk1("start_while_busy", tx_busy, 1'b0);
            chk1("active_during_byte", frame_active, 1'b1);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_byte: got tx_start with data 0x%02h, expected no byte", tx_data);
            end else begin
               e = exp_q.pop_front();
               chk8("tx_byte", tx_data, e);
            end
            if (byte_idx != 0)
               chk32("byte_gap", cyc - last_start, uart_mode ? 32'd19 : 32'd13);
            last_start          = cyc;
            cur_frame[byte_idx] = tx_data;
            byte_idx++;
            if (byte_idx == 5) begin
               last_frame  = cur_frame;
               frames_done++;
               byte_idx    = 0;
            end
         end
      end
   end

   task automatic pulse(input logic [7:0] d, input logic w);
      @(negedge clk);
      sample_valid = 1'b1;
      sample_data  = d;
      temp_warn    = w;
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   task automatic wait_frames(input int unsigned n, input int unsigned budget);
      int unsigned target;
      int unsigned k;
      target = frames_done + n;
      k = 0;
      while ((frames_done < target) && (k < budget)) begin
         @(negedge clk);
         k++;
      end
      chk1("frames_within_budget", frames_done >= target, 1'b1);
   endtask

   task automatic wait_idle(input int unsigned budget);
      int unsigned k;
      k = 0;
      while (frame_active && (k < budget)) begin
         @(negedge clk);
         k++;
      end
      chk1("frame_active_drop", frame_active, 1'b0);
   endtask

   task automatic wait_active(input int unsigned budget);
      int unsigned k;
      k = 0;
      while (!frame_active && (k < budget)) begin
         @(negedge clk);
         k++;
      end
      chk1("frame_active_rise", frame_active, 1'b1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      exp_q.delete();
      m_seq = 8'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int unsigned k;
      rst_n        = 1'b0;
      sample_valid = 1'b0;
      sample_data  = 8'h00;
      temp_warn    = 1'b0;
      uart_mode    = 1'b0;
      m_seq        = 8'd0;

      repeat (3) @(negedge clk);
      chk1("reset_tx_start", tx_start, 1'b0);
      chk8("reset_tx_data", tx_data, 8'h00);
      chk1("reset_frame_active", frame_active, 1'b0);
      chk1("reset_overrun", overrun, 1'b0);
      rst_n = 1'b1;

      // basic frame and first-byte latency
      expect_frame(8'h3C, 1'b0, 1'b0);
      pulse(8'h3C, 1'b0);
      repeat (2) @(negedge clk);
      chk1("latency_tx_start", tx_start, 1'b1);
      chk8("latency_first_byte", tx_data, 8'hA5);
      wait_frames(1, 200);
      chk_frame("basic_frame", 40'hA5_00_3C_00_1F);
      wait_idle(50);

      // warning flag and sequence
      expect_frame(8'h50, 1'b1, 1'b0);
      pulse(8'h50, 1'b1);
      wait_frames(1, 200);
      chk_frame("warn_frame", 40'hA5_01_50_01_09);
      wait_idle(50);
      expect_frame(8'h7F, 1'b0, 1'b0);
      pulse(8'h7F, 1'b0);
      wait_frames(1, 200);
      chk8("third_frame_seq", last_frame[1], 8'h02);
      wait_idle(50);

      // overrun
      do_reset();
      expect_frame(8'hAA, 1'b0, 1'b0);
      pulse(8'hAA, 1'b0);
      wait_active(20);
      pulse(8'h11, 1'b0);
      pulse(8'h22, 1'b0);
      expect_frame(8'h22, 1'b0, 1'b1);
      chk1("overrun_set", overrun, 1'b1);
      wait_frames(2, 400);
      chk_frame("overrun_frame", 40'hA5_01_22_02_36);
      wait_idle(50);
      expect_frame(8'h33, 1'b0, 1'b0);
      pulse(8'h33, 1'b0);
      wait_frames(1, 200);
      chk8("ovr_flag_cleared", last_frame[3], 8'h00);
      chk1("overrun_sticky", overrun, 1'b1);
      wait_idle(50);

      // busy timeout: UART never raises tx_busy
      uart_mode = 1'b1;
      expect_frame(8'h5A, 1'b1, 1'b0);
      pulse(8'h5A, 1'b1);
      wait_frames(1, 400);
      wait_idle(50);
      uart_mode = 1'b0;

      // reset mid-frame, with a sample waiting in the pending register
      expect_frame(8'h66, 1'b0, 1'b0);
      pulse(8'h66, 1'b0);
      wait_active(20);
      pulse(8'h77, 1'b0);
      k = 0;
      while ((byte_idx < 2) && (k < 200)) begin
         @(negedge clk);
         k++;
      end
      chk1("reached_byte2", byte_idx >= 2, 1'b1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      m_seq = 8'd0;
      #1;
      chk1("midreset_tx_start", tx_start, 1'b0);
      chk1("midreset_frame_active", frame_active, 1'b0);
      chk8("midreset_tx_data", tx_data, 8'h00);
      chk1("midreset_overrun", overrun, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      expect_frame(8'h40, 1'b0, 1'b0);
      pulse(8'h40, 1'b0);
      wait_frames(1, 200);
      chk_frame("post_reset_frame", 40'hA5_00_40_00_1B);
      wait_idle(50);

      // sequence wrap
      do_reset();
      for (int i = 0; i <= 256; i++) begin
         expect_frame(8'h00, 1'b0, 1'b0);
         pulse(8'h00, 1'b0);
         wait_frames(1, 200);
         if (i == 255) begin
            chk8("wrap_seq_ff", last_frame[1], 8'hFF);
            chk8("wrap_csum_5c", last_frame[4], 8'h5C);
         end
         if (i == 256) begin
            chk8("wrap_seq_00", last_frame[1], 8'h00);
         end
      end
      wait_idle(50);
      chk32("leftover_expected_bytes", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
